// File: rtl/hns_pkg.sv
// Shared definitions for the HNS window aggregator.
// Contents:
//   HASH_W, METRIC_W  widths of the hash and of each HNS metric
//   agg_state_e       aggregator FSM encodings (visible on the agg_state debug port)
//   umax              unsigned max of two metrics
package hns_pkg;

  localparam int HASH_W   = 256;
  localparam int METRIC_W = 32;
  localparam int STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    AGG_IDLE    = 3'd0,
    AGG_ARM     = 3'd1,
    AGG_WAIT    = 3'd2,
    AGG_RELEASE = 3'd3,
    AGG_ACCUM   = 3'd4,
    AGG_EMIT    = 3'd5
  } agg_state_e;

  function automatic logic [METRIC_W-1:0] umax(input logic [METRIC_W-1:0] a,
                                               input logic [METRIC_W-1:0] b);
    logic [METRIC_W-1:0] r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/hns_metric_accum.sv
// Window accumulator for one HNS metric.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   clear         zero the accumulator (wins over add_en)
//   add_en        add din into the accumulator this cycle
//   din           unsigned metric sample
//   acc           running sum; WINDOW_LOG2 guard bits so a full window never overflows
module hns_metric_accum
  import hns_pkg::*;
#(
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            add_en,
  input  logic [METRIC_W-1:0]             din,
  output logic [METRIC_W+WINDOW_LOG2-1:0] acc
);

  localparam int ACC_W = METRIC_W + WINDOW_LOG2;

  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  // Next accumulator value: clear, add or hold.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + {{WINDOW_LOG2{1'b0}}, din};
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hns_window_aggregator.sv
// Sequencer and windowed statistics stage around the HNS converter.
// Takes one hash at a time (valid/ready), runs one HNS conversion per hash,
// averages the four returned metrics over 2^WINDOW_LOG2 good samples and
// raises emergence after PERSIST consecutive windows with mean phi >= PHI_THRESH.
// Ports:
//   hash_valid/hash_ready/hash_data   upstream hash handshake
//   hns_hash/hns_enable               request to the HNS converter (hash held while enabled)
//   hns_valid/hns_energy/.../hns_coherence  converter result
//   win_valid                         one-cycle pulse when win_* are updated
//   win_energy/entropy/phi/coherence  window means (truncated)
//   win_max_phi                       max phi within the window
//   emergence                         sustained high mean phi
//   timeout_err                       sticky: a conversion timed out
//   agg_state                         FSM state for debug
module hns_window_aggregator
  import hns_pkg::*;
#(
  parameter int          WINDOW_LOG2 = 4,
  parameter logic [31:0] PHI_THRESH  = 32'h0080_0000,
  parameter int          PERSIST     = 3,
  parameter int          TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hash_valid,
  output logic                hash_ready,
  input  logic [HASH_W-1:0]   hash_data,
  output logic [HASH_W-1:0]   hns_hash,
  output logic                hns_enable,
  input  logic                hns_valid,
  input  logic [METRIC_W-1:0] hns_energy,
  input  logic [METRIC_W-1:0] hns_entropy,
  input  logic [METRIC_W-1:0] hns_phi,
  input  logic [METRIC_W-1:0] hns_coherence,
  output logic                win_valid,
  output logic [METRIC_W-1:0] win_energy,
  output logic [METRIC_W-1:0] win_entropy,
  output logic [METRIC_W-1:0] win_phi,
  output logic [METRIC_W-1:0] win_coherence,
  output logic [METRIC_W-1:0] win_max_phi,
  output logic                emergence,
  output logic                timeout_err,
  output logic [STATE_W-1:0]  agg_state
);

  localparam int ACC_W = METRIC_W + WINDOW_LOG2;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0]       TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]       TMR_MAX   = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0]       TMR_ONE   = TMR_W'(1);
  localparam logic [WINDOW_LOG2-1:0] CNT_LAST  = {WINDOW_LOG2{1'b1}};
  localparam logic [WINDOW_LOG2-1:0] CNT_ONE   = WINDOW_LOG2'(1);
  localparam logic [3:0]             PERSIST_V = 4'(PERSIST);

  agg_state_e state_d, state_q;
  logic [HASH_W-1:0]      hash_d, hash_q;
  logic                   hash_ready_d, hash_ready_q;
  logic                   hns_enable_d, hns_enable_q;
  logic [TMR_W-1:0]       timer_d, timer_q;
  logic                   sample_ok_d, sample_ok_q;
  logic [METRIC_W-1:0]    cap_energy_d, cap_energy_q;
  logic [METRIC_W-1:0]    cap_entropy_d, cap_entropy_q;
  logic [METRIC_W-1:0]    cap_phi_d, cap_phi_q;
  logic [METRIC_W-1:0]    cap_coherence_d, cap_coherence_q;
  logic [WINDOW_LOG2-1:0] count_d, count_q;
  logic [METRIC_W-1:0]    max_phi_d, max_phi_q;
  logic                   win_valid_d, win_valid_q;
  logic [METRIC_W-1:0]    win_energy_d, win_energy_q;
  logic [METRIC_W-1:0]    win_entropy_d, win_entropy_q;
  logic [METRIC_W-1:0]    win_phi_d, win_phi_q;
  logic [METRIC_W-1:0]    win_coherence_d, win_coherence_q;
  logic [METRIC_W-1:0]    win_max_phi_d, win_max_phi_q;
  logic [3:0]             pcnt_d, pcnt_q;
  logic                   emergence_d, emergence_q;
  logic                   timeout_err_d, timeout_err_q;

  logic                   acc_clear_s;
  logic                   acc_add_s;
  logic [ACC_W-1:0]       acc_energy_s, acc_entropy_s, acc_phi_s, acc_coherence_s;
  logic [METRIC_W-1:0]    mean_phi_s;

  hns_metric_accum #(.WINDOW_LOG2(WINDOW_LOG2)) u_acc_energy (
    .clk(clk), .reset_n(reset_n), .clear(acc_clear_s), .add_en(acc_add_s),
    .din(cap_energy_q), .acc(acc_energy_s));
  hns_metric_accum #(.WINDOW_LOG2(WINDOW_LOG2)) u_acc_entropy (
    .clk(clk), .reset_n(reset_n), .clear(acc_clear_s), .add_en(acc_add_s),
    .din(cap_entropy_q), .acc(acc_entropy_s));
  hns_metric_accum #(.WINDOW_LOG2(WINDOW_LOG2)) u_acc_phi (
    .clk(clk), .reset_n(reset_n), .clear(acc_clear_s), .add_en(acc_add_s),
    .din(cap_phi_q), .acc(acc_phi_s));
  hns_metric_accum #(.WINDOW_LOG2(WINDOW_LOG2)) u_acc_coherence (
    .clk(clk), .reset_n(reset_n), .clear(acc_clear_s), .add_en(acc_add_s),
    .din(cap_coherence_q), .acc(acc_coherence_s));

  // Dividing by the power-of-two window is just dropping the guard bits.
  assign mean_phi_s = acc_phi_s[ACC_W-1:WINDOW_LOG2];

  // Next-state and datapath control for the sequencer FSM.
  always_comb begin
    state_d         = state_q;
    hash_d          = hash_q;
    timer_d         = timer_q;
    sample_ok_d     = sample_ok_q;
    cap_energy_d    = cap_energy_q;
    cap_entropy_d   = cap_entropy_q;
    cap_phi_d       = cap_phi_q;
    cap_coherence_d = cap_coherence_q;
    count_d         = count_q;
    max_phi_d       = max_phi_q;
    win_valid_d     = 1'b0;
    win_energy_d    = win_energy_q;
    win_entropy_d   = win_entropy_q;
    win_phi_d       = win_phi_q;
    win_coherence_d = win_coherence_q;
    win_max_phi_d   = win_max_phi_q;
    pcnt_d          = pcnt_q;
    emergence_d     = emergence_q;
    timeout_err_d   = timeout_err_q;
    acc_clear_s     = 1'b0;
    acc_add_s       = 1'b0;

    case (state_q)
      AGG_IDLE: begin
        if (hash_valid && hash_ready_q) begin
          hash_d  = hash_data;
          state_d = AGG_ARM;
        end else begin
          state_d = AGG_IDLE;
        end
      end
      AGG_ARM: begin
        timer_d = '0;
        state_d = AGG_WAIT;
      end
      AGG_WAIT: begin
        if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_ONE;
        end else begin
          timer_d = timer_q;
        end
        // A result arriving on the last allowed cycle still counts.
        if (hns_valid) begin
          cap_energy_d    = hns_energy;
          cap_entropy_d   = hns_entropy;
          cap_phi_d       = hns_phi;
          cap_coherence_d = hns_coherence;
          sample_ok_d     = 1'b1;
          state_d         = AGG_RELEASE;
        end else if (timer_q == TMR_LAST) begin
          timeout_err_d = 1'b1;
          sample_ok_d   = 1'b0;
          state_d       = AGG_RELEASE;
        end else begin
          state_d = AGG_WAIT;
        end
      end
      AGG_RELEASE: begin
        // Wait for the converter to drop valid so one result is counted once.
        if (hns_valid) begin
          state_d = AGG_RELEASE;
        end else if (sample_ok_q) begin
          state_d = AGG_ACCUM;
        end else begin
          state_d = AGG_IDLE;
        end
      end
      AGG_ACCUM: begin
        acc_add_s = 1'b1;
        max_phi_d = umax(max_phi_q, cap_phi_q);
        count_d   = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          state_d = AGG_EMIT;
        end else begin
          state_d = AGG_IDLE;
        end
      end
      AGG_EMIT: begin
        win_energy_d    = acc_energy_s[ACC_W-1:WINDOW_LOG2];
        win_entropy_d   = acc_entropy_s[ACC_W-1:WINDOW_LOG2];
        win_phi_d       = mean_phi_s;
        win_coherence_d = acc_coherence_s[ACC_W-1:WINDOW_LOG2];
        win_max_phi_d   = max_phi_q;
        win_valid_d     = 1'b1;
        acc_clear_s     = 1'b1;
        max_phi_d       = '0;
        if (mean_phi_s >= PHI_THRESH) begin
          if (pcnt_q >= PERSIST_V) begin
            pcnt_d = PERSIST_V;
          end else begin
            pcnt_d = pcnt_q + 4'd1;
          end
          if (pcnt_d == PERSIST_V) begin
            emergence_d = 1'b1;
          end else begin
            emergence_d = 1'b0;
          end
        end else begin
          pcnt_d      = 4'd0;
          emergence_d = 1'b0;
        end
        state_d = AGG_IDLE;
      end
      default: begin
        state_d = AGG_IDLE;
      end
    endcase

    // Handshake and enable are registered copies of the next state.
    hash_ready_d = (state_d == AGG_IDLE);
    hns_enable_d = (state_d == AGG_WAIT);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= AGG_IDLE;
      hash_q          <= '0;
      hash_ready_q    <= 1'b0;
      hns_enable_q    <= 1'b0;
      timer_q         <= '0;
      sample_ok_q     <= 1'b0;
      cap_energy_q    <= '0;
      cap_entropy_q   <= '0;
      cap_phi_q       <= '0;
      cap_coherence_q <= '0;
      count_q         <= '0;
      max_phi_q       <= '0;
      win_valid_q     <= 1'b0;
      win_energy_q    <= '0;
      win_entropy_q   <= '0;
      win_phi_q       <= '0;
      win_coherence_q <= '0;
      win_max_phi_q   <= '0;
      pcnt_q          <= 4'd0;
      emergence_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      hash_q          <= hash_d;
      hash_ready_q    <= hash_ready_d;
      hns_enable_q    <= hns_enable_d;
      timer_q         <= timer_d;
      sample_ok_q     <= sample_ok_d;
      cap_energy_q    <= cap_energy_d;
      cap_entropy_q   <= cap_entropy_d;
      cap_phi_q       <= cap_phi_d;
      cap_coherence_q <= cap_coherence_d;
      count_q         <= count_d;
      max_phi_q       <= max_phi_d;
      win_valid_q     <= win_valid_d;
      win_energy_q    <= win_energy_d;
      win_entropy_q   <= win_entropy_d;
      win_phi_q       <= win_phi_d;
      win_coherence_q <= win_coherence_d;
      win_max_phi_q   <= win_max_phi_d;
      pcnt_q          <= pcnt_d;
      emergence_q     <= emergence_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign hash_ready    = hash_ready_q;
  assign hns_hash      = hash_q;
  assign hns_enable    = hns_enable_q;
  assign win_valid     = win_valid_q;
  assign win_energy    = win_energy_q;
  assign win_entropy   = win_entropy_q;
  assign win_phi       = win_phi_q;
  assign win_coherence = win_coherence_q;
  assign win_max_phi   = win_max_phi_q;
  assign emergence     = emergence_q;
  assign timeout_err   = timeout_err_q;
  assign agg_state     = state_q;

endmodule
